// File: rtl/ll_pkg.sv
// ll_pkg -- constants shared by the linked-list scheduler and its benches.
//   state_e : scheduler FSM states (ARB = normal arbitration, FLUSH = drain one list)
//   op_e    : operation type, used as the push/pop priority token
package ll_pkg;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_POP  = 1'b1
   } op_e;

endpackage : ll_pkg

// File: rtl/ll_rr_arb.sv
// ll_rr_arb -- purely combinational round-robin picker.
//   req     : request vector, one bit per list
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant (zero when no request)
//   any_gnt : some request was granted
//   nxt_ptr : pointer to use after this grant is taken, (granted + 1) mod N
module ll_rr_arb #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          any_gnt,
   output logic [IW-1:0] nxt_ptr
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before any conditional assignment,
      // so no path through the block leaves a value held -- no latch inferred.
      gnt     = '0;
      any_gnt = 1'b0;
      nxt_ptr = ptr;
      // Scan from ptr upward with wrap-around; the first hit wins.
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any_gnt && req[idx]) begin
            any_gnt  = 1'b1;
            gnt[idx] = 1'b1;
            nxt_ptr  = IW'((idx + 1) % N);
         end
      end
   end

endmodule : ll_rr_arb

// File: rtl/ll_scheduler.sv
// ll_scheduler -- arbitrates per-list push/pop requests onto a shared linked_list
// and runs single-list drain (flush) operations.
//   clk, rst            : clock, synchronous active-high reset
//   push_req, pop_req   : level requests per list, held until granted
//   flush_req/flush_sel : one-cycle request to drain list flush_sel
//   full, empty         : status from linked_list
//   push, pop           : commands to linked_list; also the grant to the requester
//   flush_busy          : draining in progress
//   flush_done          : one-cycle pulse when the drained list is empty
module ll_scheduler
   import ll_pkg::*;
#(
   parameter int NUM_LISTS = 2,
   parameter int NUM_ELEMS = 4,
   parameter int IDX_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_LISTS-1:0] push_req,
   input  logic [NUM_LISTS-1:0] pop_req,
   input  logic                 flush_req,
   input  logic [IDX_WIDTH-1:0] flush_sel,
   input  logic                 full,
   input  logic [NUM_LISTS-1:0] empty,
   output logic [NUM_LISTS-1:0] push,
   output logic [NUM_LISTS-1:0] pop,
   output logic                 flush_busy,
   output logic                 flush_done
);

   state_e               state_q, state_d;
   op_e                  prio_q, prio_d;
   logic [IDX_WIDTH-1:0] push_ptr_q, push_ptr_d;
   logic [IDX_WIDTH-1:0] pop_ptr_q, pop_ptr_d;
   logic [IDX_WIDTH-1:0] sel_q, sel_d;

   logic [NUM_LISTS-1:0] elig_push, elig_pop;
   logic [NUM_LISTS-1:0] push_gnt, pop_gnt;
   logic                 push_any, pop_any;
   logic [IDX_WIDTH-1:0] push_nxt, pop_nxt;
   logic                 do_push, do_pop;

   // A full list blocks every push; an empty list blocks only its own pop.
   assign elig_push = push_req & {NUM_LISTS{!full}};
   assign elig_pop  = pop_req & ~empty;

   ll_rr_arb #(.N(NUM_LISTS), .IW(IDX_WIDTH)) u_push_arb (
      .req     (elig_push),
      .ptr     (push_ptr_q),
      .gnt     (push_gnt),
      .any_gnt (push_any),
      .nxt_ptr (push_nxt)
   );

   ll_rr_arb #(.N(NUM_LISTS), .IW(IDX_WIDTH)) u_pop_arb (
      .req     (elig_pop),
      .ptr     (pop_ptr_q),
      .gnt     (pop_gnt),
      .any_gnt (pop_any),
      .nxt_ptr (pop_nxt)
   );

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      push_ptr_d = push_ptr_q;
      pop_ptr_d  = pop_ptr_q;
      sel_d      = sel_q;
      push       = '0;
      pop        = '0;
      flush_busy = 1'b0;
      flush_done = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;

      case (state_q)
         ST_ARB: begin
            // The favoured type goes first; the other type only fills an idle slot.
            if (prio_q == OP_PUSH) begin
               do_push = push_any;
               do_pop  = !push_any && pop_any;
            end else begin
               do_pop  = pop_any;
               do_push = !pop_any && push_any;
            end
            if (do_push) begin
               push       = push_gnt;
               push_ptr_d = push_nxt;
               prio_d     = OP_POP;
            end
            if (do_pop) begin
               pop       = pop_gnt;
               pop_ptr_d = pop_nxt;
               prio_d    = OP_PUSH;
            end
            if (flush_req && (int'(flush_sel) < NUM_LISTS)) begin
               sel_d   = flush_sel;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush_busy = 1'b1;
            if (!empty[sel_q]) begin
               pop[sel_q] = 1'b1;
            end else begin
               flush_done = 1'b1;
               state_d    = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase

      // Commands are suppressed while reset is asserted, independent of state.
      if (rst) begin
         push       = '0;
         pop        = '0;
         flush_busy = 1'b0;
         flush_done = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples the
   // pre-edge value of every other, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ARB;
         prio_q     <= OP_PUSH;
         push_ptr_q <= '0;
         pop_ptr_q  <= '0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         push_ptr_q <= push_ptr_d;
         pop_ptr_q  <= pop_ptr_d;
         sel_q      <= sel_d;
      end
   end

endmodule : ll_scheduler

// File: doc/ll_scheduler.md
LL_SCHEDULER -- requirements
Module: ll_scheduler

Interface
REQ-001 Parameter NUM_LISTS, default 2: number of lists and requester slots; must match the attached linked_list.
REQ-002 Parameter NUM_ELEMS, default 4: shared-memory depth of the attached linked_list; informational for benches.
REQ-003 Parameter IDX_WIDTH, default max(1,$clog2(NUM_LISTS)): list-index width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 push_req  input  NUM_LISTS  level request per list to append; held until granted.
REQ-007 pop_req  input  NUM_LISTS  level request per list to remove head; held until granted.
REQ-008 flush_req  input  1  one-cycle request to drain list flush_sel.
REQ-009 flush_sel  input  IDX_WIDTH  list to drain; sampled with flush_req.
REQ-010 full  input  1  from linked_list.
REQ-011 empty  input  NUM_LISTS  from linked_list.
REQ-012 push  output  NUM_LISTS  to linked_list push; doubles as push grant/ack to requester.
REQ-013 pop  output  NUM_LISTS  to linked_list pop; doubles as pop grant/ack.
REQ-014 flush_busy  output  1  high while in FLUSH state.
REQ-015 flush_done  output  1  one-cycle pulse when a drain completes.

Function
REQ-016 At most one bit across {push,pop} shall be set in any cycle; the list never sees simultaneous push and pop.
REQ-017 push/pop shall be combinational from registered state and current inputs (zero-cycle grant); list full/empty are therefore current for every decision.
REQ-018 Eligible pushes = push_req & {NUM_LISTS{!full}}; eligible pops = pop_req & ~empty.
REQ-019 FSM states ARB, FLUSH; reset state ARB.
REQ-020 ARB: if prio==PUSH and eligible pushes nonzero, grant one push; else if eligible pops nonzero, grant one pop; else if eligible pushes nonzero, grant one push; mirror order when prio==POP.
REQ-021 After any grant, prio flips to the opposite type; with no grant, prio is unchanged.
REQ-022 Within a type, round-robin: grant lowest eligible index at or cyclically after that type's pointer; pointer then becomes (granted+1) mod NUM_LISTS; push and pop pointers are independent.
REQ-023 Full with pending pops: pops granted regardless of prio.
REQ-024 flush_req with flush_sel<NUM_LISTS in ARB: that cycle's normal grant still occurs; flush_sel is registered; next state FLUSH. flush_sel>=NUM_LISTS is ignored.
REQ-025 FLUSH: pop[sel_q] asserted every cycle while !empty[sel_q]; all push_req/pop_req receive no grant; flush_req ignored.
REQ-026 FLUSH with empty[sel_q]: no pop, flush_done=1 that cycle, next state ARB; an already-empty list gives flush_done on the first FLUSH cycle.
REQ-027 flush_busy = (state==FLUSH); prio and RR pointers hold during FLUSH.

Reset
REQ-028 While rst=1: push=0, pop=0, flush_done=0, flush_busy=0 combinationally.
REQ-029 On the reset edge: state=ARB, prio=PUSH, both RR pointers=0, sel_q=0; reset mid-FLUSH abandons the drain without flush_done.

Structure
REQ-030 State encoding (ARB/FLUSH) and type encoding (PUSH/POP) are constants in shared package ll_pkg, also usable by linked_list benches.
REQ-031 One sub-module, ll_rr_arb (request vector, pointer in; one-hot grant, any-grant out, next pointer), instantiated twice (push, pop).

Verification (NUM_LISTS=2, NUM_ELEMS=4, attached to linked_list)
REQ-032 After reset, push_req=2'b11 held -> push=01,10,01,10 on four consecutive cycles; then full=1 and push=00.
REQ-033 push_req=2'b01 and pop_req=2'b01 held continuously, list 0 initially empty -> cycle1 push=01; thereafter pop and push alternate, never both set.
REQ-034 4 elements total, full=1, push_req=11, pop_req=10 -> pop=10 granted first; next cycle push granted.
REQ-035 List 1 holds 3 elements, flush_req=1 with flush_sel=1 -> flush_busy=1 for 4 cycles, pop=10 on 3 consecutive cycles, flush_done on the 4th, push_req ungranted throughout; ARB resumes next cycle.
REQ-036 pop_req=2'b01 on empty list 0 -> no grant until a push to list 0 completes, then pop=01 the following cycle.
REQ-037 rst asserted during the second FLUSH cycle -> pop=00 immediately, no flush_done; state ARB, prio PUSH after release.
